riscv_fetch_queue: RTL

Instruction-fetch stage with prefetch buffer for the pipelined RISC-V core. Issues sequential word fetches to a 1-cycle-latency instruction memory and buffers returned instructions with their PCs in a small FIFO. Presents them to the decode stage through a valid/ready handshake. Discards all buffered and in-flight fetches on a redirect from branch/jump resolution.

---
 rtl/riscv_fetch_queue_if.sv | 26 ++
 rtl/riscv_fetch_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect input and decode handshake.
// master = fetch queue side, slave = memory/decode environment side.
interface riscv_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                         imem_req;
    logic [31:0]                  imem_addr;
    logic [31:0]                  imem_rdata;
    logic                         redirect_valid;
    logic [31:0]                  redirect_pc;
    logic                         id_ready;
    logic                         id_valid;
    logic [31:0]                  id_instr;
    logic [31:0]                  id_pc;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, occupancy,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, occupancy,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Sequential instruction prefetch into a small {pc, instr} FIFO with redirect flush.
// Optional FETCH_STATS_EN adds stat_flushes / stat_bubbles counters.
module riscv_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    riscv_fetch_queue_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         stat_flushes,
    output logic [31:0]         stat_bubbles
`endif
);
    localparam int              AW    = $clog2(DEPTH);
    localparam int              OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W:0]  LIMIT = DEPTH[OCC_W:0];

    logic              r_start;
    logic [31:0]       r_fetch_pc;
    logic              r_inflight;
    logic [31:0]       r_inflight_pc;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [31:0]       r_mem_pc    [DEPTH];
    logic [31:0]       r_mem_instr [DEPTH];

    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [OCC_W:0]    w_credit;
    logic              w_unused_pc_lsbs;

    // Credit counts the in-flight response so it always finds a free slot.
    assign w_credit = {1'b0, r_count} + {{OCC_W{1'b0}}, r_inflight};
    assign w_req    = r_start & ~bus.redirect_valid & (w_credit < LIMIT);
    assign w_valid  = (r_count != '0);
    assign w_push   = r_inflight & ~bus.redirect_valid;
    assign w_pop    = w_valid & bus.id_ready & ~bus.redirect_valid;
    assign w_unused_pc_lsbs = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start    <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_start    <= 1'b1;
            r_inflight <= w_req;
            if (bus.redirect_valid) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_req)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + OCC_W'(1);
                    2'b01:   r_count <= r_count - OCC_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is qualified by the control state above, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_req)
            r_inflight_pc <= r_fetch_pc;
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
            r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.id_valid  = w_valid;
    assign bus.id_instr  = w_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign bus.id_pc     = w_valid ? r_mem_pc[r_rd_ptr]    : 32'd0;
    assign bus.occupancy = r_count;

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_flushes;
    logic [31:0] r_stat_bubbles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_flushes <= 32'd0;
            r_stat_bubbles <= 32'd0;
        end else begin
            if (bus.redirect_valid)
                r_stat_flushes <= r_stat_flushes + 32'd1;
            if (r_start & ~w_valid)
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
        end
    end

    assign stat_flushes = r_stat_flushes;
    assign stat_bubbles = r_stat_bubbles;
`endif
endmodule
